// File: rtl/ula_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ula_ctrl
//  Description : Multi-cycle control unit for a small register/ALU datapath.
//                Instructions are accepted from IDLE on Run. Each one is then
//                sequenced through T1..T3. All datapath controls are a pure
//                decode of the FSM state and the latched instruction (IR).
//
//  Ports
//    Clock      in   1   system clock, rising-edge active
//    Resetn     in   1   asynchronous active-low reset
//    Run        in   1   start request, sampled only in IDLE
//    Instr      in   16  [15:12] opcode, [11:9] Rx, [8:6] Ry, [5:0] imm6
//    BusSel     out  2   00 reg RegSel, 01 G, 10 zero-extended imm6, 11 none
//    RegSel     out  N   register driven onto the bus when BusSel=00
//    Ain        out  1   load ALU A-register from the bus
//    Gin        out  1   load G-register from the ALU output
//    ALUop      out  4   ALU operation (the opcode itself, only in T2)
//    RegWr      out  1   write the bus into RegWrAddr at the next edge
//    RegWrAddr  out  N   destination register
//    Busy       out  1   an instruction is in flight (T1..T3)
//    Done       out  1   single-cycle completion pulse
//    Err        out  1   completion was an illegal opcode
//    InstrCnt   out  16  completed-instruction counter, wraps at FFFF
//
//  Revision    : 1.0  initial release
// ============================================================================
module ula_ctrl #(
    parameter int NREG_BITS = 3
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic                 Run,
    input  logic [15:0]          Instr,
    output logic [1:0]           BusSel,
    output logic [NREG_BITS-1:0] RegSel,
    output logic                 Ain,
    output logic                 Gin,
    output logic [3:0]           ALUop,
    output logic                 RegWr,
    output logic [NREG_BITS-1:0] RegWrAddr,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Err,
    output logic [15:0]          InstrCnt
);

    // ------------------------------------------------------------------------
    // Instruction field layout: opcode in the top nibble, then Rx, then Ry,
    // with whatever remains below Ry being the immediate.
    // ------------------------------------------------------------------------
    localparam int c_RX_LSB = 12 - NREG_BITS;
    localparam int c_RY_LSB = 12 - 2 * NREG_BITS;

    localparam logic [3:0] c_OP_MV  = 4'b0000;
    localparam logic [3:0] c_OP_MVI = 4'b0001;
    localparam logic [3:0] c_OP_ADD = 4'b0101;
    localparam logic [3:0] c_OP_SUB = 4'b0110;
    localparam logic [3:0] c_OP_OR  = 4'b0111;
    localparam logic [3:0] c_OP_SLT = 4'b1000;
    localparam logic [3:0] c_OP_SRL = 4'b1001;
    localparam logic [3:0] c_OP_SLL = 4'b1010;

    localparam logic [1:0] c_BUS_REG  = 2'b00;
    localparam logic [1:0] c_BUS_G    = 2'b01;
    localparam logic [1:0] c_BUS_IMM  = 2'b10;
    localparam logic [1:0] c_BUS_NONE = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_T1   = 2'd1,
        S_T2   = 2'd2,
        S_T3   = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] instr_cnt_q, instr_cnt_d;

    // ------------------------------------------------------------------------
    // IR field decode
    // ------------------------------------------------------------------------
    logic [3:0]           w_opcode;
    logic [NREG_BITS-1:0] w_rx;
    logic [NREG_BITS-1:0] w_ry;
    logic                 w_is_alu;
    logic                 w_ir_imm_unused;

    assign w_opcode = ir_q[15:12];
    assign w_rx     = ir_q[c_RX_LSB +: NREG_BITS];
    assign w_ry     = ir_q[c_RY_LSB +: NREG_BITS];

    // The immediate is routed to the bus by the datapath directly; the
    // controller only selects it, so those IR bits are not decoded here.
    assign w_ir_imm_unused = &{1'b0, ir_q[c_RY_LSB-1:0]};

    always_comb begin
        w_is_alu = 1'b0;
        case (w_opcode)
            c_OP_ADD, c_OP_SUB, c_OP_OR,
            c_OP_SLT, c_OP_SRL, c_OP_SLL: w_is_alu = 1'b1;
            default:                      w_is_alu = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------------
    // State register. Reset is asynchronous so that every output, being a
    // decode of state_q, returns to its idle value without a clock edge.
    // ------------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= S_IDLE;
            ir_q        <= 16'h0000;
            instr_cnt_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output decode. Only IDLE looks at Run/Instr; in every
    // other state the outputs depend on state_q and ir_q alone.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        BusSel    = c_BUS_NONE;
        RegSel    = '0;
        Ain       = 1'b0;
        Gin       = 1'b0;
        ALUop     = 4'b0000;
        RegWr     = 1'b0;
        RegWrAddr = '0;
        Busy      = 1'b0;
        Done      = 1'b0;
        Err       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Run) begin
                    ir_d    = Instr;
                    state_d = S_T1;
                end
            end

            S_T1: begin
                Busy = 1'b1;
                if (w_opcode == c_OP_MV) begin
                    BusSel    = c_BUS_REG;
                    RegSel    = w_ry;
                    RegWr     = 1'b1;
                    RegWrAddr = w_rx;
                    Done      = 1'b1;
                    state_d   = S_IDLE;
                end else if (w_opcode == c_OP_MVI) begin
                    BusSel    = c_BUS_IMM;
                    RegWr     = 1'b1;
                    RegWrAddr = w_rx;
                    Done      = 1'b1;
                    state_d   = S_IDLE;
                end else if (w_is_alu) begin
                    BusSel  = c_BUS_REG;
                    RegSel  = w_rx;
                    Ain     = 1'b1;
                    state_d = S_T2;
                end else begin
                    // Illegal opcode: retire with an error, touch nothing.
                    Done    = 1'b1;
                    Err     = 1'b1;
                    state_d = S_IDLE;
                end
            end

            S_T2: begin
                Busy = 1'b1;
                if (w_is_alu) begin
                    BusSel  = c_BUS_REG;
                    RegSel  = w_ry;
                    ALUop   = w_opcode;
                    Gin     = 1'b1;
                    state_d = S_T3;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_T3: begin
                Busy = 1'b1;
                if (w_is_alu) begin
                    BusSel    = c_BUS_G;
                    RegWr     = 1'b1;
                    RegWrAddr = w_rx;
                    Done      = 1'b1;
                end
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Counts on the edge that leaves a Done cycle; natural 16-bit wrap.
    assign instr_cnt_d = instr_cnt_q + {15'd0, Done};
    assign InstrCnt    = instr_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ula_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ula_ctrl
//  Description : Directed self-checking bench for ula_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ula_ctrl;

    logic        Clock;
    logic        Resetn;
    logic        Run;
    logic [15:0] Instr;
    logic [1:0]  BusSel;
    logic [2:0]  RegSel;
    logic        Ain;
    logic        Gin;
    logic [3:0]  ALUop;
    logic        RegWr;
    logic [2:0]  RegWrAddr;
    logic        Busy;
    logic        Done;
    logic        Err;
    logic [15:0] InstrCnt;

    int n_checks = 0;
    int n_fail   = 0;

    ula_ctrl #(.NREG_BITS(3)) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .Run       (Run),
        .Instr     (Instr),
        .BusSel    (BusSel),
        .RegSel    (RegSel),
        .Ain       (Ain),
        .Gin       (Gin),
        .ALUop     (ALUop),
        .RegWr     (RegWr),
        .RegWrAddr (RegWrAddr),
        .Busy      (Busy),
        .Done      (Done),
        .Err       (Err),
        .InstrCnt  (InstrCnt)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] rx,
                                       input logic [2:0] ry, input logic [5:0] imm);
        return {op, rx, ry, imm};
    endfunction

    task automatic step();
        @(negedge Clock);
    endtask

    // Outputs expected whenever the controller is idle.
    task automatic check_idle(input string tag);
        check({tag, ".BusSel"},    32'(BusSel),    32'd3);
        check({tag, ".Busy"},      32'(Busy),      32'd0);
        check({tag, ".Done"},      32'(Done),      32'd0);
        check({tag, ".Err"},       32'(Err),       32'd0);
        check({tag, ".RegWr"},     32'(RegWr),     32'd0);
        check({tag, ".Ain"},       32'(Ain),       32'd0);
        check({tag, ".Gin"},       32'(Gin),       32'd0);
        check({tag, ".ALUop"},     32'(ALUop),     32'd0);
        check({tag, ".RegSel"},    32'(RegSel),    32'd0);
        check({tag, ".RegWrAddr"}, 32'(RegWrAddr), 32'd0);
    endtask

    initial begin
        Resetn = 1'b0;
        Run    = 1'b0;
        Instr  = 16'h0000;

        // ---------------- reset state (before any clock edge) ---------------
        #1;
        check_idle("rst");
        check("rst.InstrCnt", 32'(InstrCnt), 32'd0);

        // ---------------- ADD R2,R5 accepted on first edge after reset ------
        step();
        Resetn = 1'b1;
        Instr  = mk(4'b0101, 3'd2, 3'd5, 6'd0);
        Run    = 1'b1;
        step();
        Run    = 1'b0;
        Instr  = 16'hFFFF;
        check("add.T1.BusSel", 32'(BusSel), 32'd0);
        check("add.T1.RegSel", 32'(RegSel), 32'd2);
        check("add.T1.Ain",    32'(Ain),    32'd1);
        check("add.T1.ALUop",  32'(ALUop),  32'd0);
        check("add.T1.Busy",   32'(Busy),   32'd1);
        check("add.T1.Done",   32'(Done),   32'd0);
        step();
        check("add.T2.BusSel", 32'(BusSel), 32'd0);
        check("add.T2.RegSel", 32'(RegSel), 32'd5);
        check("add.T2.ALUop",  32'(ALUop),  32'h5);
        check("add.T2.Gin",    32'(Gin),    32'd1);
        check("add.T2.Ain",    32'(Ain),    32'd0);
        check("add.T2.RegWr",  32'(RegWr),  32'd0);
        step();
        check("add.T3.BusSel",    32'(BusSel),    32'd1);
        check("add.T3.RegWr",     32'(RegWr),     32'd1);
        check("add.T3.RegWrAddr", 32'(RegWrAddr), 32'd2);
        check("add.T3.Done",      32'(Done),      32'd1);
        check("add.T3.ALUop",     32'(ALUop),     32'd0);
        check("add.T3.Cnt",       32'(InstrCnt),  32'd0);
        step();
        check_idle("add.idle");
        check("add.Cnt", 32'(InstrCnt), 32'd1);

        // ---------------- MVI R7,0x2A ---------------------------------------
        Instr = mk(4'b0001, 3'd7, 3'd0, 6'h2A);
        Run   = 1'b1;
        step();
        Run   = 1'b0;
        check("mvi.BusSel",    32'(BusSel),    32'd2);
        check("mvi.RegWr",     32'(RegWr),     32'd1);
        check("mvi.RegWrAddr", 32'(RegWrAddr), 32'd7);
        check("mvi.Done",      32'(Done),      32'd1);
        check("mvi.Busy",      32'(Busy),      32'd1);
        step();
        check_idle("mvi.idle");
        check("mvi.Cnt", 32'(InstrCnt), 32'd2);

        // ---------------- MV R3,R4 ------------------------------------------
        Instr = mk(4'b0000, 3'd3, 3'd4, 6'd0);
        Run   = 1'b1;
        step();
        Run   = 1'b0;
        check("mv.BusSel",    32'(BusSel),    32'd0);
        check("mv.RegSel",    32'(RegSel),    32'd4);
        check("mv.RegWrAddr", 32'(RegWrAddr), 32'd3);
        check("mv.RegWr",     32'(RegWr),     32'd1);
        check("mv.Done",      32'(Done),      32'd1);
        check("mv.Err",       32'(Err),       32'd0);
        step();
        check("mv.Cnt", 32'(InstrCnt), 32'd3);

        // ---------------- illegal opcode 1111 -------------------------------
        Instr = mk(4'b1111, 3'd1, 3'd1, 6'd0);
        Run   = 1'b1;
        step();
        Run   = 1'b0;
        check("ill.Done",   32'(Done),   32'd1);
        check("ill.Err",    32'(Err),    32'd1);
        check("ill.RegWr",  32'(RegWr),  32'd0);
        check("ill.Ain",    32'(Ain),    32'd0);
        check("ill.Gin",    32'(Gin),    32'd0);
        check("ill.BusSel", 32'(BusSel), 32'd3);
        check("ill.Busy",   32'(Busy),   32'd1);
        step();
        check_idle("ill.idle");
        check("ill.Cnt", 32'(InstrCnt), 32'd4);

        // ---------------- SLT R1,R2 with Run held, Instr changed in T2 ------
        Instr = mk(4'b1000, 3'd1, 3'd2, 6'd0);
        Run   = 1'b1;
        step();
        check("slt.T1.RegSel", 32'(RegSel), 32'd1);
        check("slt.T1.Ain",    32'(Ain),    32'd1);
        step();
        check("slt.T2.ALUop", 32'(ALUop), 32'h8);
        Instr = mk(4'b0000, 3'd5, 3'd6, 6'd0);
        #1;
        check("slt.T2.ALUop.live", 32'(ALUop),  32'h8);
        check("slt.T2.RegSel",     32'(RegSel), 32'd2);
        step();
        check("slt.T3.Done",      32'(Done),      32'd1);
        check("slt.T3.RegWrAddr", 32'(RegWrAddr), 32'd1);
        check("slt.T3.BusSel",    32'(BusSel),    32'd1);
        step();
        check("slt.idle.Busy", 32'(Busy),     32'd0);
        check("slt.idle.Done", 32'(Done),     32'd0);
        check("slt.Cnt",       32'(InstrCnt), 32'd5);
        step();
        // Fourth edge after the SLT acceptance takes the MV.
        Run = 1'b0;
        check("mv2.Done",      32'(Done),      32'd1);
        check("mv2.BusSel",    32'(BusSel),    32'd0);
        check("mv2.RegSel",    32'(RegSel),    32'd6);
        check("mv2.RegWrAddr", 32'(RegWrAddr), 32'd5);
        step();
        check("mv2.Cnt", 32'(InstrCnt), 32'd6);

        // ---------------- Rx == Ry ------------------------------------------
        Instr = mk(4'b0111, 3'd4, 3'd4, 6'd0);
        Run   = 1'b1;
        step();
        Run   = 1'b0;
        check("or.T1.RegSel", 32'(RegSel), 32'd4);
        step();
        check("or.T2.RegSel", 32'(RegSel), 32'd4);
        check("or.T2.ALUop",  32'(ALUop),  32'h7);
        step();
        check("or.T3.RegWrAddr", 32'(RegWrAddr), 32'd4);
        step();
        check("or.Cnt", 32'(InstrCnt), 32'd7);

        // ---------------- reset during T3 of SUB ----------------------------
        Instr = mk(4'b0110, 3'd3, 3'd4, 6'd0);
        Run   = 1'b1;
        step();
        Run   = 1'b0;
        step();
        check("sub.T2.ALUop", 32'(ALUop), 32'h6);
        step();
        check("sub.T3.RegWr", 32'(RegWr), 32'd1);
        check("sub.T3.Done",  32'(Done),  32'd1);
        #2;
        Resetn = 1'b0;
        #1;
        check_idle("sub.rst");
        check("sub.rst.Cnt", 32'(InstrCnt), 32'd0);
        step();
        check_idle("sub.rst.hold");
        check("sub.rst.hold.Cnt", 32'(InstrCnt), 32'd0);

        // ---------------- accept on first edge after reset release ----------
        Resetn = 1'b1;
        Instr  = mk(4'b0000, 3'd2, 3'd1, 6'd0);
        Run    = 1'b1;
        step();
        Run    = 1'b0;
        check("post.Done",   32'(Done),   32'd1);
        check("post.RegSel", 32'(RegSel), 32'd1);
        step();
        check("post.Cnt", 32'(InstrCnt), 32'd1);

        // ---------------- InstrCnt wrap FFFF -> 0000 ------------------------
        force dut.instr_cnt_q = 16'hFFFF;
        #1;
        release dut.instr_cnt_q;
        #1;
        check("wrap.pre", 32'(InstrCnt), 32'hFFFF);
        Instr = mk(4'b0000, 3'd0, 3'd7, 6'd0);
        Run   = 1'b1;
        step();
        Run   = 1'b0;
        check("wrap.Done", 32'(Done),     32'd1);
        check("wrap.mid",  32'(InstrCnt), 32'hFFFF);
        step();
        check("wrap.post", 32'(InstrCnt), 32'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ula_ctrl.md
ULA_CTRL -- requirements
Module: ula_ctrl

Interface
REQ-001 The block SHALL have the following parameter: NREG_BITS, default 3, width of register-select fields (8 registers).
REQ-002 The block SHALL have the following ports: Clock  in  1  single system clock, all state changes on rising edge.
REQ-003 The block SHALL have the following port: Resetn  in  1  asynchronous, active-low reset.
REQ-004 The block SHALL have the following port: Run  in  1  start request; sampled only in IDLE.
REQ-005 The block SHALL have the following port: Instr  in  16  instruction word: [15:12] opcode, [11:9] Rx, [8:6] Ry, [5:0] imm6.
REQ-006 The block SHALL have the following port: BusSel  out  2  bus source: 00 register RegSel, 01 G register, 10 zero-extended imm6, 11 none.
REQ-007 The block SHALL have the following port: RegSel  out  3  register driven onto bus when BusSel=00.
REQ-008 The block SHALL have the following ports: Ain out 1, load ALU A-register from bus; Gin out 1, load G-register from ALU output.
REQ-009 The block SHALL have the following port: ALUop  out  4  ALU operation code.
REQ-010 The block SHALL have the following ports: RegWr out 1, write bus into RegWrAddr (out 3) at the next edge.
REQ-011 The block SHALL have the following ports: Busy out 1, Done out 1, Err out 1, InstrCnt out 16.

Function
REQ-012 Opcodes SHALL be: MV 0000, MVI 0001, ADD 0101, SUB 0110, OR 0111, SLT 1000, SRL 1001, SLL 1010; all others illegal.
REQ-013 States SHALL be IDLE, T1, T2, T3; the encoding is free.
REQ-014 In IDLE with Run=1 at an edge, the block SHALL latch Instr into internal IR and go to T1; with Run=0 it SHALL stay in IDLE.
REQ-015 Run and Instr SHALL be ignored outside IDLE; IR SHALL hold until the next acceptance.
REQ-016 Outputs SHALL be combinational decode of the state and IR only, with no dependency on the live Instr or Run.
REQ-017 IDLE outputs SHALL be: BusSel=11, Ain=Gin=RegWr=Done=Err=Busy=0, ALUop=0000, RegSel=RegWrAddr=0.
REQ-018 Busy SHALL be 1 in T1, T2 and T3.
REQ-019 For MV, T1 SHALL drive BusSel=00, RegSel=Ry, RegWr=1, RegWrAddr=Rx and Done=1, then return to IDLE.
REQ-020 For MVI, T1 SHALL drive BusSel=10, RegWr=1, RegWrAddr=Rx and Done=1, then return to IDLE.
REQ-021 For an ALU operation, T1 SHALL drive BusSel=00, RegSel=Rx and Ain=1, then go to T2.
REQ-022 For an ALU operation, T2 SHALL drive BusSel=00, RegSel=Ry, ALUop=IR[15:12] and Gin=1, then go to T3.
REQ-023 For an ALU operation, T3 SHALL drive BusSel=01, RegWr=1, RegWrAddr=Rx and Done=1, then return to IDLE.
REQ-024 For an illegal opcode, T1 SHALL assert Done=1 and Err=1 with RegWr=Ain=Gin=0 and BusSel=11, then return to IDLE.
REQ-025 Latency from the accepting edge SHALL be: the Done cycle is the 1st cycle for MV/MVI/illegal and the 3rd cycle for ALU ops.
REQ-026 Done SHALL be a single-cycle pulse; the minimum issue interval SHALL be 2 cycles (MV) or 4 cycles (ALU), because an IDLE cycle always follows Done.
REQ-027 ALUop SHALL be 0000 in every state other than T2.
REQ-028 Rx=Ry SHALL be legal and SHALL need no special handling.
REQ-029 InstrCnt SHALL increment by 1 on every edge that leaves a Done cycle, Err included.
REQ-030 InstrCnt SHALL wrap from FFFF to 0000.

Reset
REQ-031 Resetn=0 SHALL immediately force the IDLE state, IR=0 and InstrCnt=0, and all outputs to the IDLE values, in any state and without waiting for a clock.
REQ-032 Reset mid-instruction SHALL abort it; RegWr SHALL drop in the same cycle as reset and no Done SHALL be issued.
REQ-033 After Resetn deasserts, the block SHALL accept Run on the first rising edge.

Verification
REQ-034 Verification SHALL cover ADD with Rx=2, Ry=5, Run for 1 cycle. Required: T1 RegSel=2, Ain=1; T2 RegSel=5, ALUop=0101, Gin=1; T3 BusSel=01, RegWr=1, RegWrAddr=2, Done=1; InstrCnt 0 to 1.
REQ-035 Verification SHALL cover MVI with Rx=7, imm6=0x2A. Required: next cycle BusSel=10, RegWr=1, RegWrAddr=7, Done=1, Busy=1, followed by IDLE.
REQ-036 Verification SHALL cover opcode 1111. Required: one cycle with Done=1 and Err=1, RegWr=0; InstrCnt increments.
REQ-037 Verification SHALL cover Run held high continuously with SLT, then Instr changed during T2. Required: the T2 ALUop stays 1000; the second instruction is accepted only from IDLE, 4 cycles after the first acceptance.
REQ-038 Verification SHALL cover Resetn pulled low during T3 of SUB. Required: RegWr and Done fall to 0 without a clock edge; state IDLE, InstrCnt=0.
REQ-039 Verification SHALL cover preloading InstrCnt to FFFF with 65535 MV instructions and then one more. Required: InstrCnt reads 0000 after that MV.
